mux4_rr_scheduler: RTL and testbench
====================================

Name: mux4_rr_scheduler

Overview:
Round-robin time-slot scheduler that shares one 4:1 strobed selector between four single-bit requesters. It arbitrates requests and drives the selector's select and strobe controls (strobe high = selector disabled, output 0). It also registers the selected data bit as the shared serial output. It sits in front of the 74153-style selector and owns its control inputs.

Parameters:
SLOT_LEN, 8, maximum grant length in clock cycles (legal range 1..255)
GAP_EN, 1, 1 = insert one strobed guard cycle between grants; 0 = back-to-back grants

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_in  input  4  per-requester request, level, held while data is being sent
data_in  input  4  per-requester serial data bit
gnt_out  output  4  one-hot grant, registered
sel_out  output  2  selector select code = index of granted requester, registered
strobe_out  output  1  selector strobe, 1 = disabled, registered
busy_out  output  1  1 while in GRANT or GAP
y_out  output  1  registered selected data bit

Behaviour:
- One clock; reset is asynchronous and active-low. On rst_n low, at any time including mid-grant:
  - state=IDLE, gnt_out=0, sel_out=0, strobe_out=1, busy_out=0, y_out=0.
  - slot counter=0, last-owner pointer=3, so requester 0 has first priority.
- Arbitration (comb): the winner is the first requester with req_in high, scanning from (last+1) mod 4 upward with wrap. The owner just released therefore gets lowest priority. It is regranted if it is the only requester.
- States:
  - IDLE:
    - strobe_out=1, gnt_out=0.
    - If any req_in is high at the edge: next state GRANT with gnt_out=onehot(winner), sel_out=winner, strobe_out=0, counter=1.
    - Request-to-grant latency is 1 cycle.
  - GRANT:
    - Outputs hold. Counter increments each cycle.
    - The grant ends at the edge where counter==SLOT_LEN, or where req_in[owner]==0 (early release takes effect that same edge).
    - On end: last=owner.
    - If GAP_EN=1: go to GAP with gnt_out=0, strobe_out=1; sel_out holds.
    - If GAP_EN=0: arbitrate immediately. Load the new GRANT (counter=1) if any request is pending, else go to IDLE.
  - GAP:
    - Exactly 1 cycle with strobe_out=1, gnt_out=0.
    - Then go to GRANT for the winner if any request is pending, else IDLE.
- A held request gets exactly SLOT_LEN consecutive cycles of gnt_out high.
- A request that drops and rises again in the same cycle window is treated as a new request at the next arbitration.
- sel_out changes only when a new grant loads. It never changes while strobe_out=0.
- y_out timing: y_out(t+1) = strobe_out(t) ? 0 : data_in[sel_out(t)]. Latency is 1 cycle behind the select/strobe state.
- busy_out=1 in GRANT and GAP, 0 in IDLE.
- Requests arriving while another grant is active wait; they are never dropped while held.

Test Plan:
- Reset: drive rst_n=0 mid-stream -> same cycle: gnt_out=0000, sel_out=00, strobe_out=1, y_out=0, busy_out=0. After release with no requests, outputs stay at these values.
- Single held request, req_in=0100, SLOT_LEN=8, GAP_EN=1:
  - One cycle after the request: gnt_out=0100, sel_out=10, strobe_out=0 for 8 cycles.
  - Then 1 gap cycle with strobe_out=1, gnt_out=0.
  - Then regrant to requester 2.
- All four held, req_in=1111, GAP_EN=1: grant order 0,1,2,3,0, each 8 cycles, separated by single strobe-high gap cycles. Repeat with GAP_EN=0 -> order 0,1,2,3 with no gap; strobe_out stays 0 and gnt_out switches on the 9th edge.
- Early release: req_in=1010, requester 1 granted, req_in[1] dropped after 3 grant cycles -> gnt_out falls at that edge, 1 gap cycle, then gnt_out=1000, sel_out=11.
- Data path: grant to requester 1, data_in=1010 -> y_out=1 one cycle after strobe_out falls. data_in[1] toggling is tracked with 1-cycle lag. y_out=0 in the cycle after the gap cycle.
- Mid-grant async reset during a SLOT_LEN=8 grant at cycle 4 -> outputs return to reset values immediately. After release with req_in=0010, requester 1 is granted first and gets a full 8 cycles, since the pointer was reset to 3.

Source files
------------

// File: rtl/mux4_rr_scheduler.sv
// mux4_rr_scheduler: round-robin slot scheduler driving a shared 4:1 strobed selector
module mux4_rr_scheduler #(
    parameter int SLOT_LEN = 8,
    parameter bit GAP_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic [3:0] data_in,
    output logic [3:0] gnt_out,
    output logic [1:0] sel_out,
    output logic       strobe_out,
    output logic       busy_out,
    output logic       y_out
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    logic [1:0] state, last, ptr, win;
    logic [7:0] cnt;
    logic       done;
    // while granted the owner is the pointer, so back-to-back arbitration skips it
    assign ptr = (state == GRANT) ? sel_out : last;
    assign done = (state == GRANT) && (cnt == 8'(SLOT_LEN) || !req_in[sel_out]);
    assign busy_out = (state != IDLE);
    always_comb begin
        win = ptr;
        for (int i = 4; i >= 1; i--)
            if (req_in[2'(ptr + 2'(i))]) win = 2'(ptr + 2'(i));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_out    <= 4'b0;
            sel_out    <= 2'd0;
            strobe_out <= 1'b1;
            y_out      <= 1'b0;
            cnt        <= 8'd0;
            last       <= 2'd3;
        end else begin
            y_out <= !strobe_out && data_in[sel_out];
            if (state == GRANT && !done) begin
                cnt <= cnt + 8'd1;
            end else if (state == GRANT && GAP_EN) begin
                last       <= sel_out;
                state      <= GAP;
                gnt_out    <= 4'b0;
                strobe_out <= 1'b1;
                cnt        <= 8'd0;
            end else if (|req_in) begin
                if (state == GRANT) last <= sel_out;
                state      <= GRANT;
                gnt_out    <= 4'b1 << win;
                sel_out    <= win;
                strobe_out <= 1'b0;
                cnt        <= 8'd1;
            end else begin
                if (state == GRANT) last <= sel_out;
                state      <= IDLE;
                gnt_out    <= 4'b0;
                strobe_out <= 1'b1;
                cnt        <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// tb_mux4_rr_scheduler: random and directed stimulus against a slot-level reference model
module tb_mux4_rr_scheduler;
    localparam int SL = 8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_in = 4'b0;
    logic [3:0] data_in = 4'b0;
    logic [3:0] gnt [2];
    logic [1:0] sel [2];
    logic       strobe [2];
    logic       busy [2];
    logic       y [2];
    int n_chk = 0;
    int n_fail = 0;
    bit m_act [2];
    bit m_gap [2];
    bit m_y [2];
    int m_own [2];
    int m_used [2];
    int m_last [2];

    always #5 clk = ~clk;

    mux4_rr_scheduler #(.SLOT_LEN(SL), .GAP_EN(1'b1)) dut_gap (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .data_in(data_in),
        .gnt_out(gnt[0]), .sel_out(sel[0]), .strobe_out(strobe[0]),
        .busy_out(busy[0]), .y_out(y[0])
    );
    mux4_rr_scheduler #(.SLOT_LEN(SL), .GAP_EN(1'b0)) dut_nogap (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .data_in(data_in),
        .gnt_out(gnt[1]), .sel_out(sel[1]), .strobe_out(strobe[1]),
        .busy_out(busy[1]), .y_out(y[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            m_act[m] = 0; m_gap[m] = 0; m_y[m] = 0;
            m_own[m] = 0; m_used[m] = 0; m_last[m] = 3;
        end
    endtask

    task automatic m_grant(input int m, input int ptr);
        for (int k = 1; k <= 4; k++)
            if (req_in[(ptr + k) % 4]) begin
                m_act[m] = 1; m_own[m] = (ptr + k) % 4; m_used[m] = 1;
                return;
            end
    endtask

    // model instance 0 inserts guard cycles, instance 1 runs grants back to back
    task automatic m_step();
        for (int m = 0; m < 2; m++) begin
            m_y[m] = m_act[m] && data_in[m_own[m]];
            if (m_act[m]) begin
                if (m_used[m] == SL || !req_in[m_own[m]]) begin
                    m_last[m] = m_own[m];
                    m_act[m] = 0;
                    if (m == 0) m_gap[m] = 1;
                    else m_grant(m, m_own[m]);
                end else m_used[m]++;
            end else begin
                m_gap[m] = 0;
                m_grant(m, m_last[m]);
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("%s gnt%0d", tag, m), 32'(gnt[m]), m_act[m] ? 32'(1 << m_own[m]) : 0);
            check($sformatf("%s sel%0d", tag, m), 32'(sel[m]), 32'(m_own[m]));
            check($sformatf("%s strobe/busy/y%0d", tag, m), {29'd0, strobe[m], busy[m], y[m]},
                  {29'd0, !m_act[m], m_act[m] || m_gap[m], m_y[m]});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) m_step();
        @(negedge clk);
        check_all("run");
        data_in = 4'($urandom);
    endtask

    task automatic areset();
        #2 rst_n = 1'b0;
        m_reset();
        #1 check_all("arst");
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();
        req_in = 4'b0100;
        repeat (30) cycle();
        req_in = 4'b1111;
        repeat (45) cycle();
        req_in = 4'b0000;
        repeat (3) cycle();
        areset();
        req_in = 4'b1010;
        repeat (3) cycle();
        req_in = 4'b1000;
        repeat (12) cycle();
        req_in = 4'b0000;
        repeat (3) cycle();
        areset();
        req_in = 4'b0010;
        repeat (4) cycle();
        areset();
        repeat (12) cycle();
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(9) == 0) req_in[b] = ~req_in[b];
            if ($urandom_range(499) == 0) areset();
            else cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
